// File: rtl/uart_tx_fifo_if.sv
// Word handshake between the packet/text generator and the UART transmitter FIFO.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in;

  modport master (
    output in_valid,
    output in,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in,
    output in_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO and internal baud divider on the system clock.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter  int DATA_BITS    = 8,
  parameter  int CLKS_PER_BIT = 16,
  parameter  int STOP_BITS    = 1,
  parameter  int FIFO_DEPTH   = 4,
  localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus,
  input  logic           enable,
  input  logic           parity_odd,
  output logic           out,
  output logic           done,
  output logic           busy,
  output logic           fifo_empty,
  output logic [LW-1:0]  level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX    = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX    = IW'(DATA_BITS - 1);
  localparam logic          STOP_MAX   = (STOP_BITS == 2);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level_q;
  logic                 full, push, pop, can_pop;
  logic [DATA_BITS-1:0] head;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // in_ready comes only from registered occupancy, so a same-cycle pop never makes room.
  assign full          = (level_q == FULL_LEVEL);
  assign bus.in_ready  = !full;
  assign push          = bus.in_valid && !full;
  assign fifo_empty    = (level_q == '0);
  assign level         = level_q;
  assign can_pop       = !fifo_empty && enable;
  assign head          = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // The final stop edge may pop straight into START so queued frames run without a gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          par_d   = (^head) ^ parity_odd;
`endif
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_MAX) begin
            stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (stop_q == STOP_MAX) begin
            done_d = 1'b1;
            if (can_pop) begin
              pop     = 1'b1;
              shift_d = head;
`ifdef UART_TX_PARITY_EN
              par_d   = (^head) ^ parity_odd;
`endif
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out = 1'b1;
    case (state_q)
      START:   out = 1'b0;
      DATA:    out = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  out = par_q;
`endif
      default: out = 1'b1;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule
